kvadd_tutorial_example_axis_gen: RTL
====================================

Name: kvadd_tutorial_example_axis_gen

Overview:
AXI4-Stream transmitter that produces the stimulus stream consumed by the kernel's pipelined adder. On a start command it emits a programmed number of 512-bit beats. Each 32-bit lane carries an incrementing value derived from a seed, and tlast is set on the final beat. It sits in front of the adder's slave stream port and reports completion to kernel control with a one-cycle done pulse.

Parameters:
C_AXIS_TDATA_WIDTH, 512, width of m_axis_tdata; must be a multiple of C_ADDER_BIT_WIDTH.
C_ADDER_BIT_WIDTH, 32, lane width; LANES = C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH (16 at default).
C_XFER_SIZE_WIDTH, 32, width of the beat-count command.
C_AXIS_TID_WIDTH, 1, tid width.
C_AXIS_TDEST_WIDTH, 1, tdest width.
C_AXIS_TUSER_WIDTH, 1, tuser width.

Ports:
aclk  in  1  single clock for the whole block.
aresetn  in  1  reset, asynchronous assert, active-low.
ctrl_start  in  1  start pulse; sampled only in IDLE.
ctrl_num_beats  in  C_XFER_SIZE_WIDTH  number of beats to send; sampled with ctrl_start.
ctrl_seed  in  C_ADDER_BIT_WIDTH  value of lane 0 of beat 0; sampled with ctrl_start.
ctrl_busy  out  1  high while a transfer is in progress (RUN or DONE).
ctrl_done  out  1  one-cycle completion pulse.
m_axis_tvalid  out  1  AXIS valid.
m_axis_tready  in  1  AXIS ready.
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  beat data.
m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  constant all ones.
m_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  constant all ones.
m_axis_tlast  out  1  high on the final beat only.
m_axis_tid  out  C_AXIS_TID_WIDTH  constant zero.
m_axis_tdest  out  C_AXIS_TDEST_WIDTH  constant zero.
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  constant zero.

Behaviour:
- Clocking and reset: one clock (aclk); reset asynchronous, active-low (aresetn).
- While aresetn is low: state=IDLE; tvalid, tlast, ctrl_busy, ctrl_done all 0; beat counter 0; tdata 0.
- States:
  - IDLE: ctrl_start=1 latches num_beats and seed.
    - num_beats!=0: next state RUN.
    - num_beats==0: next state DONE; no beat is ever emitted.
  - RUN: tvalid=1. A handshake (tvalid&tready) advances to the next beat. The handshake on the final beat moves to DONE.
  - DONE: ctrl_done=1 for exactly one cycle, then IDLE.
- ctrl_start outside IDLE is ignored; latched values do not change.
- Latency: with start sampled at edge E, tvalid=1 and beat 0 are visible in the cycle after E.
- Throughput: with tready held high, one beat per cycle and no bubbles.
- ctrl_done is asserted in the cycle after the last handshake.
- Data rule: lane k of beat n = seed + n*LANES + k, truncated to C_ADDER_BIT_WIDTH (modulo 2^32, wraps silently).
- Implementation: a registered base value is incremented by LANES per handshake; per-lane adds run off that base. The tdata register is loaded before it is presented.
- tlast=1 only while beat num_beats-1 is presented; num_beats=1 gives tlast on beat 0.
- AXIS rules:
  - Once tvalid=1, tvalid, tdata and tlast stay stable until the handshake.
  - tvalid never depends combinationally on tready.
  - All outputs are registered.
- Beat counter counts handshakes, 0..num_beats-1. num_beats = 2^C_XFER_SIZE_WIDTH-1 must complete without counter overflow.
- Reset mid-transfer: outputs drop immediately (asynchronously); no done pulse; the remaining beats are discarded. After release, the block is in IDLE and accepts a new start.

Test Plan:
1. seed=0, num_beats=1, tready=1 -> one beat, lanes 0..15 = 0x0..0xF, tlast=1; ctrl_done pulses the cycle after the handshake; ctrl_busy is high from start+1 until done, inclusive.
2. seed=0x100, num_beats=4, tready=1, start at edge E -> handshakes in cycles E+1..E+4; lane0 = 0x100, 0x110, 0x120, 0x130; tlast only on beat 4; ctrl_done=1 in cycle E+5 only.
3. num_beats=6, tready pattern 1,0,0,1,0,1,1,1,... -> exactly 6 handshakes; tdata and tlast held constant through every stall; tkeep/tstrb all ones; tid/tdest/tuser zero.
4. seed=0xFFFFFFF8, num_beats=2 -> beat0: lane7=0xFFFFFFFF, lane8=0x00000000, lane15=0x00000007; beat1: lane0=0x00000008.
5. num_beats=0 -> tvalid never asserts; ctrl_done pulses at E+1. A second ctrl_start issued during RUN of a 3-beat transfer -> ignored, still exactly 3 beats.
6. aresetn driven low after 2 of 8 handshakes -> tvalid, ctrl_busy and tlast go to 0 without waiting for a clock edge; no ctrl_done. After release, start with seed=0x20, num_beats=1 -> single beat with lane0=0x20, tlast=1.

Source files
------------

// File: rtl/kvadd_tutorial_example_axis_gen.sv
// rtl/kvadd_tutorial_example_axis_gen.sv - AXI4-Stream beat generator with seeded incrementing lanes
module kvadd_tutorial_example_axis_gen #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_AXIS_TID_WIDTH   = 1,
  parameter int C_AXIS_TDEST_WIDTH = 1,
  parameter int C_AXIS_TUSER_WIDTH = 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              ctrl_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0]      ctrl_num_beats,
  input  logic [C_ADDER_BIT_WIDTH-1:0]      ctrl_seed,
  output logic                              ctrl_busy,
  output logic                              ctrl_done,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                              m_axis_tlast,
  output logic [C_AXIS_TID_WIDTH-1:0]       m_axis_tid,
  output logic [C_AXIS_TDEST_WIDTH-1:0]     m_axis_tdest,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser
);

  localparam int LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
  localparam logic [C_ADDER_BIT_WIDTH-1:0] LANES_W = C_ADDER_BIT_WIDTH'(LANES);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] ONE = C_XFER_SIZE_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                          state_q;
  logic [C_XFER_SIZE_WIDTH-1:0]    num_beats_q;
  logic [C_XFER_SIZE_WIDTH-1:0]    beat_cnt_q;
  logic [C_ADDER_BIT_WIDTH-1:0]    base_q;
  logic [C_ADDER_BIT_WIDTH-1:0]    base_d;
  logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_q;
  logic [C_AXIS_TDATA_WIDTH-1:0]   tdata_d;
  logic                            tvalid_q;
  logic                            tlast_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            hs_last;
  logic                            next_is_last;

  assign hs_last      = (beat_cnt_q == (num_beats_q - ONE));
  assign next_is_last = ((beat_cnt_q + ONE) == (num_beats_q - ONE));

  // Base of the beat about to be loaded (seed at start, else advance by one beat) and its lane values
  always_comb begin
    tdata_d = '0;
    base_d  = (state_q == S_IDLE) ? ctrl_seed : (base_q + LANES_W);
    for (int k = 0; k < LANES; k++) begin
      tdata_d[k*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH] = base_d + C_ADDER_BIT_WIDTH'(k);
    end
  end

  // Control FSM; every stream and control output is a register updated here
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      num_beats_q <= '0;
      beat_cnt_q  <= '0;
      base_q      <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ctrl_start) begin
            num_beats_q <= ctrl_num_beats;
            beat_cnt_q  <= '0;
            base_q      <= base_d;
            busy_q      <= 1'b1;
            if (ctrl_num_beats != '0) begin
              state_q  <= S_RUN;
              tvalid_q <= 1'b1;
              tdata_q  <= tdata_d;
              tlast_q  <= (ctrl_num_beats == ONE);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (m_axis_tready) begin
            if (hs_last) begin
              state_q  <= S_DONE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + ONE;
              base_q     <= base_d;
              tdata_q    <= tdata_d;
              tlast_q    <= next_is_last;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tstrb  = '1;
  assign m_axis_tid    = '0;
  assign m_axis_tdest  = '0;
  assign m_axis_tuser  = '0;

endmodule
